// File: rtl/lcd_byte_writer_pkg.sv
// Shared types, HD44780 command constants and helpers for the character-LCD writer.
// The init ROM is packed LSB-first: entry 0 sits in bits [7:0].
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP     = 3'd0,
        ST_INIT_LOAD = 3'd1,
        ST_SETUP     = 3'd2,
        ST_EN_HI     = 3'd3,
        ST_HOLD      = 3'd4,
        ST_EXEC      = 3'd5,
        ST_IDLE      = 3'd6
    } lcd_state_e;

    localparam logic [7:0] LCD_FUNC_8B2L  = 8'h38;
    localparam logic [7:0] LCD_DISP_ON    = 8'h0C;
    localparam logic [7:0] LCD_CLEAR      = 8'h01;
    localparam logic [7:0] LCD_ENTRY_INC  = 8'h06;
    localparam logic [7:0] LCD_LINE2_ADDR = 8'hC0;

    localparam int unsigned LCD_INIT_LEN = 4;

    localparam logic [LCD_INIT_LEN*8-1:0] LCD_INIT_ROM =
        {LCD_ENTRY_INC, LCD_CLEAR, LCD_DISP_ON, LCD_FUNC_8B2L};

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return (!rs) && (data[7:2] == 6'd0) && (data != 8'd0);
    endfunction

    // A zero-length wait is stretched to one cycle so every state is visible.
    function automatic int unsigned cyc_or_one(input int unsigned n);
        return (n == 0) ? 1 : n;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_byte_writer_if.sv
// Upstream byte handshake: the display formatter is the master, the LCD writer the slave.
interface lcd_byte_writer_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_rs;
    logic [7:0] in_data;

    modport master (
        output in_valid,
        output in_rs,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_rs,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/lcd_byte_writer_delay_timer.sv
// Reloadable down-counter shared by every timed state of the LCD writer.
// done is high while the count is zero; the owner loads N-1 on state entry.
module lcd_delay_timer #(
    parameter int unsigned          W         = 8,
    parameter logic [W-1:0]         RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_done
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_count <= RESET_VAL;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/lcd_byte_writer.sv
// HD44780 8-bit write-only controller: power-up init, then one byte per
// valid/ready handshake with setup / enable / hold / execution timing.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC = 8,
    parameter int unsigned EN_CYC    = 25,
    parameter int unsigned HOLD_CYC  = 4,
    parameter int unsigned EXEC_CYC  = 2000,
    parameter int unsigned LONG_CYC  = 82000,
    parameter int unsigned PWRUP_CYC = 750000
) (
    input  logic               CLOCK_50,
    input  logic               RST,
    lcd_byte_writer_if.slave   bus,
    output logic               init_done,
    output logic               LCD_ON,
    output logic               LCD_BLON,
    output logic               LCD_EN,
    output logic               LCD_RS,
    output logic               LCD_RW,
    output logic [7:0]         LCD_DATA
);

    localparam int unsigned MAX_CYC = max2(max2(max2(SETUP_CYC, EN_CYC), max2(HOLD_CYC, EXEC_CYC)),
                                           max2(LONG_CYC, PWRUP_CYC));
    localparam int unsigned TW      = $clog2(MAX_CYC) + 1;

    localparam logic [TW-1:0] SETUP_LD = TW'(cyc_or_one(SETUP_CYC) - 1);
    localparam logic [TW-1:0] EN_LD    = TW'(cyc_or_one(EN_CYC) - 1);
    localparam logic [TW-1:0] HOLD_LD  = TW'(cyc_or_one(HOLD_CYC) - 1);
    localparam logic [TW-1:0] EXEC_LD  = TW'(cyc_or_one(EXEC_CYC) - 1);
    localparam logic [TW-1:0] LONG_LD  = TW'(cyc_or_one(LONG_CYC) - 1);
    localparam logic [TW-1:0] PWRUP_LD = TW'(cyc_or_one(PWRUP_CYC) - 1);

    lcd_state_e r_state;
    lcd_state_e w_state_next;

    logic [1:0]    r_idx, w_idx_next;
    logic          r_init_done, w_init_done_next;
    logic          r_in_ready, w_in_ready_next;
    logic          r_lcd_en, w_lcd_en_next;
    logic          r_lcd_rs, w_lcd_rs_next;
    logic [7:0]    r_lcd_data, w_lcd_data_next;

    logic          w_accept;
    logic          w_timer_done;
    logic          w_timer_load;
    logic [TW-1:0] w_timer_value;

    assign w_accept = (r_state == ST_IDLE) && r_in_ready && bus.in_valid;

    lcd_delay_timer #(
        .W         (TW),
        .RESET_VAL (PWRUP_LD)
    ) u_timer (
        .clk     (CLOCK_50),
        .srst    (RST),
        .i_load  (w_timer_load),
        .i_value (w_timer_value),
        .o_done  (w_timer_done)
    );

    // State register together with the registered pin outputs.
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            r_state     <= ST_PWRUP;
            r_idx       <= 2'd0;
            r_init_done <= 1'b0;
            r_in_ready  <= 1'b0;
            r_lcd_en    <= 1'b0;
            r_lcd_rs    <= 1'b0;
            r_lcd_data  <= 8'h00;
        end else begin
            r_state     <= w_state_next;
            r_idx       <= w_idx_next;
            r_init_done <= w_init_done_next;
            r_in_ready  <= w_in_ready_next;
            r_lcd_en    <= w_lcd_en_next;
            r_lcd_rs    <= w_lcd_rs_next;
            r_lcd_data  <= w_lcd_data_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_PWRUP:     if (w_timer_done) w_state_next = ST_INIT_LOAD;
            ST_INIT_LOAD: w_state_next = ST_SETUP;
            ST_SETUP:     if (w_timer_done) w_state_next = ST_EN_HI;
            ST_EN_HI:     if (w_timer_done) w_state_next = ST_HOLD;
            ST_HOLD:      if (w_timer_done) w_state_next = ST_EXEC;
            ST_EXEC: begin
                if (w_timer_done) begin
                    if (r_init_done || (r_idx == 2'd3)) w_state_next = ST_IDLE;
                    else                                w_state_next = ST_INIT_LOAD;
                end
            end
            ST_IDLE:      if (w_accept) w_state_next = ST_SETUP;
            default:      w_state_next = ST_PWRUP;
        endcase
    end

    // The timer is reloaded on every state change with the new state's length.
    always_comb begin
        w_timer_load  = (w_state_next != r_state);
        w_timer_value = '0;
        unique case (w_state_next)
            ST_PWRUP: w_timer_value = PWRUP_LD;
            ST_SETUP: w_timer_value = SETUP_LD;
            ST_EN_HI: w_timer_value = EN_LD;
            ST_HOLD:  w_timer_value = HOLD_LD;
            ST_EXEC:  w_timer_value = is_long_cmd(r_lcd_rs, r_lcd_data) ? LONG_LD : EXEC_LD;
            default:  w_timer_value = '0;
        endcase
    end

    always_comb begin
        w_idx_next       = r_idx;
        w_init_done_next = r_init_done;
        w_lcd_rs_next    = r_lcd_rs;
        w_lcd_data_next  = r_lcd_data;
        w_lcd_en_next    = (w_state_next == ST_EN_HI);
        w_in_ready_next  = (w_state_next == ST_IDLE);

        if (r_state == ST_INIT_LOAD) begin
            w_lcd_rs_next   = 1'b0;
            w_lcd_data_next = LCD_INIT_ROM[{r_idx, 3'b000} +: 8];
        end

        if (w_accept) begin
            w_lcd_rs_next   = bus.in_rs;
            w_lcd_data_next = bus.in_data;
        end

        if ((r_state == ST_EXEC) && w_timer_done && !r_init_done) begin
            if (r_idx == 2'd3) w_init_done_next = 1'b1;
            else               w_idx_next       = r_idx + 2'd1;
        end
    end

    assign bus.in_ready = r_in_ready;
    assign init_done    = r_init_done;
    assign LCD_ON       = 1'b1;
    assign LCD_BLON     = 1'b1;
    assign LCD_EN       = r_lcd_en;
    assign LCD_RS       = r_lcd_rs;
    assign LCD_RW       = 1'b0;
    assign LCD_DATA     = r_lcd_data;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Bench for lcd_byte_writer: a monitor logs every EN pulse, and each task compares
// the log against pulse times computed from the timing rules.
module tb_lcd_byte_writer;

    localparam int SETUP = 2, EN = 3, HOLD = 1, EXEC = 5, LONG = 20, PWRUP = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init_done, lcd_on, lcd_blon, lcd_en, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;

    lcd_byte_writer_if bus ();

    lcd_byte_writer #(
        .SETUP_CYC (SETUP), .EN_CYC (EN), .HOLD_CYC (HOLD),
        .EXEC_CYC (EXEC), .LONG_CYC (LONG), .PWRUP_CYC (PWRUP)
    ) dut (
        .CLOCK_50 (clk), .RST (rst), .bus (bus), .init_done (init_done),
        .LCD_ON (lcd_on), .LCD_BLON (lcd_blon), .LCD_EN (lcd_en),
        .LCD_RS (lcd_rs), .LCD_RW (lcd_rw), .LCD_DATA (lcd_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rw_bad = 0;

    int         q_rise[$];
    logic       q_rs[$];
    logic [7:0] q_data[$];
    int         q_width[$];
    logic       en_prev = 1'b0;
    int         rise_cyc = 0;

    logic [7:0] init_bytes [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    // Pulse logger: cyc is the index of the edge whose results are being looked at.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (lcd_rw !== 1'b0) rw_bad = rw_bad + 1;
        if (lcd_en === 1'b1 && en_prev === 1'b0) begin
            rise_cyc = cyc;
            q_rise.push_back(cyc);
            q_rs.push_back(lcd_rs);
            q_data.push_back(lcd_data);
        end
        if (lcd_en === 1'b0 && en_prev === 1'b1) q_width.push_back(cyc - rise_cyc);
        en_prev = lcd_en;
    end

    function automatic int exec_len(input logic rs, input logic [7:0] d);
        if (rs == 1'b0 && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return LONG;
        return EXEC;
    endfunction

    task automatic clear_log();
        q_rise.delete(); q_rs.delete(); q_data.delete(); q_width.delete();
    endtask

    task automatic wait_ready(input int budget, output int at, output bit ok);
        ok = 1'b0;
        at = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    // Checks the four init pulses that follow a reset released after edge r.
    task automatic check_init_log(input string tag, input int r, input int ready_at);
        int t;
        t = r + PWRUP + 1 + SETUP;
        checks++;
        if (q_rise.size() !== 4) begin
            errors++; $display("FAIL %s pulse_count got=%0d exp=4", tag, q_rise.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (q_rise[i] !== t || q_data[i] !== init_bytes[i] || q_rs[i] !== 1'b0 || q_width[i] !== EN) begin
                    errors++;
                    $display("FAIL %s init_pulse%0d got rise=%0d data=%02h rs=%0b w=%0d exp rise=%0d data=%02h rs=0 w=%0d",
                             tag, i, q_rise[i], q_data[i], q_rs[i], q_width[i], t, init_bytes[i], EN);
                end
                if (i < 3) t = t + EN + HOLD + exec_len(1'b0, init_bytes[i]) + 1 + SETUP;
            end
            checks++;
            if (ready_at !== t + EN + HOLD + exec_len(1'b0, init_bytes[3])) begin
                errors++;
                $display("FAIL %s ready_time got=%0d exp=%0d", tag, ready_at, t + EN + HOLD + exec_len(1'b0, init_bytes[3]));
            end
        end
        checks++;
        if (init_done !== 1'b1) begin
            errors++; $display("FAIL %s init_done got=%0b exp=1", tag, init_done);
        end
        $display("%s: init sequence ready at cycle %0d", tag, ready_at);
    endtask

    // Reset values, then init while upstream tries to push 0xFF the whole time.
    task automatic test_reset();
        int r, at;
        bit ok;
        bus.in_valid = 1'b1; bus.in_rs = 1'b1; bus.in_data = 8'hFF;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({lcd_on, lcd_blon, lcd_en, lcd_rs, lcd_rw, lcd_data, bus.in_ready, init_done} !== {5'b11000, 8'h00, 2'b00}) begin
            errors++;
            $display("FAIL reset_values got on=%0b bl=%0b en=%0b rs=%0b rw=%0b data=%02h rdy=%0b done=%0b exp 1 1 0 0 0 00 0 0",
                     lcd_on, lcd_blon, lcd_en, lcd_rs, lcd_rw, lcd_data, bus.in_ready, init_done);
        end
        r = cyc;
        rst = 1'b0;
        clear_log();
        wait_ready(1000, at, ok);
        bus.in_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++; $display("FAIL reset_init_timeout got=no_ready exp=ready");
        end
        check_init_log("reset_init", r, at);
    endtask

    task automatic test_single(input logic rs, input logic [7:0] d);
        int k, at, busy;
        bit ok;
        clear_log();
        bus.in_valid = 1'b1; bus.in_rs = rs; bus.in_data = d;
        k = cyc;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_rs = ~rs; bus.in_data = ~d;
        checks++;
        if (lcd_rs !== rs || lcd_data !== d || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_capture got rs=%0b data=%02h rdy=%0b exp rs=%0b data=%02h rdy=0",
                     lcd_rs, lcd_data, bus.in_ready, rs, d);
        end
        wait_ready(200, at, ok);
        busy = SETUP + EN + HOLD + exec_len(rs, d);
        checks++;
        if (!ok || at !== k + 1 + busy) begin
            errors++; $display("FAIL single_busy got=%0d exp=%0d", at - k - 1, busy);
        end
        checks++;
        if (q_rise.size() !== 1) begin
            errors++; $display("FAIL single_pulse_count got=%0d exp=1", q_rise.size());
        end else if (q_rise[0] !== k + 1 + SETUP || q_rs[0] !== rs || q_data[0] !== d || q_width[0] !== EN) begin
            errors++;
            $display("FAIL single_pulse got rise=+%0d rs=%0b data=%02h w=%0d exp rise=+%0d rs=%0b data=%02h w=%0d",
                     q_rise[0] - k, q_rs[0], q_data[0], q_width[0], 1 + SETUP, rs, d, EN);
        end
        $display("single: rs=%0b data=%02h busy=%0d", rs, d, at - k - 1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [3] = '{8'h31, 8'h32, 8'h33};
        int sent, viol, k0, at, exp_rise;
        bit ok, prev_r;
        clear_log();
        sent = 0; viol = 0; prev_r = 1'b0;
        k0 = cyc;
        bus.in_valid = 1'b1; bus.in_rs = 1'b1; bus.in_data = b[0];
        for (int n = 0; n < 400 && sent < 3; n++) begin
            if (bus.in_ready === 1'b1) begin
                if (prev_r) viol++;
                prev_r = 1'b1;
                sent++;
                @(negedge clk);
                if (sent < 3) bus.in_data = b[sent];
                else          bus.in_valid = 1'b0;
            end else begin
                prev_r = 1'b0;
                @(negedge clk);
            end
        end
        wait_ready(200, at, ok);
        checks++;
        if (!ok || sent !== 3 || viol !== 0) begin
            errors++; $display("FAIL b2b_handshake got sent=%0d long_ready=%0d exp sent=3 long_ready=0", sent, viol);
        end
        checks++;
        if (q_rise.size() !== 3) begin
            errors++; $display("FAIL b2b_pulse_count got=%0d exp=3", q_rise.size());
        end else begin
            exp_rise = k0 + 1 + SETUP;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (q_data[i] !== b[i] || q_rs[i] !== 1'b1 || q_rise[i] !== exp_rise || q_width[i] !== EN) begin
                    errors++;
                    $display("FAIL b2b_pulse%0d got data=%02h rs=%0b rise=%0d w=%0d exp data=%02h rs=1 rise=%0d w=%0d",
                             i, q_data[i], q_rs[i], q_rise[i], q_width[i], b[i], exp_rise, EN);
                end
                exp_rise = exp_rise + EN + HOLD + EXEC + 1 + SETUP;
            end
        end
        $display("back_to_back: %0d bytes sent, ready at cycle %0d", sent, at);
    endtask

    task automatic test_rst_mid();
        int r, at;
        bit ok, seen;
        seen = 1'b0;
        bus.in_valid = 1'b1; bus.in_rs = 1'b1; bus.in_data = 8'h5A;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (lcd_en === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL rst_mid_en_timeout got=no_en exp=en");
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (lcd_en !== 1'b0 || lcd_data !== 8'h00 || lcd_rs !== 1'b0 || init_done !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_values got en=%0b data=%02h rs=%0b done=%0b rdy=%0b exp 0 00 0 0 0",
                     lcd_en, lcd_data, lcd_rs, init_done, bus.in_ready);
        end
        r = cyc;
        rst = 1'b0;
        clear_log();
        wait_ready(1000, at, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL rst_mid_init_timeout got=no_ready exp=ready");
        end
        check_init_log("rst_mid", r, at);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_rs = 1'b0; bus.in_data = 8'h00;
        test_reset();
        test_single(1'b1, 8'h41);
        test_single(1'b0, 8'h01);
        test_single(1'b1, 8'h01);
        test_single(1'b0, 8'h02);
        test_single(1'b0, 8'h03);
        test_single(1'b0, 8'h04);
        test_single(1'b0, 8'h00);
        test_single(1'b0, 8'hC0);
        for (int i = 0; i < 8; i++) begin
            logic       rr;
            logic [7:0] dd;
            rr = 1'($urandom_range(1, 0));
            dd = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(3, 0)) : 8'($urandom);
            test_single(rr, dd);
        end
        test_back_to_back();
        test_rst_mid();
        checks++;
        if (rw_bad !== 0) begin
            errors++; $display("FAIL lcd_rw_low got=%0d_bad_cycles exp=0", rw_bad);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
